muldiv_unit: RTL

Iterative RV32M multiply/divide engine sitting directly downstream of `cpu_top`'s `muldiv_*` request port. It consumes the `muldiv_start` request, computes one result bit per cycle, and returns the result tagged with the issuing hart and destination register on the `muldiv_done*` return port. One operation is in flight at a time; `muldiv_busy` back-pressures both harts.

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: one result bit per cycle, fixed
// latency for every op, result returned with the hart/rd tags of the request.
module muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int HART_ID_W  = 1,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  muldiv_start,
   input  logic [2:0]            muldiv_op,
   input  logic [XLEN-1:0]       muldiv_a,
   input  logic [XLEN-1:0]       muldiv_b,
   input  logic [HART_ID_W-1:0]  muldiv_hart_id,
   input  logic [REG_ADDR_W-1:0] muldiv_rd,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [XLEN-1:0]       muldiv_result,
   output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
   output logic [REG_ADDR_W-1:0] muldiv_done_rd,
   output logic [1:0]            muldiv_dbg_state
);

   localparam int              CNT_W = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [2:0]              op_q;
   logic                    neg_q;
   logic                    rem_neg_q;
   logic                    special_q;
   logic [XLEN-1:0]         spec_res_q;
   logic [XLEN-1:0]         opnd_q;
   logic [2*XLEN-1:0]       acc_q;
   logic [HART_ID_W-1:0]    hart_q;
   logic [REG_ADDR_W-1:0]   rd_q;
   logic                    busy_q;
   logic                    done_q;
   logic [XLEN-1:0]         result_q;
   logic [HART_ID_W-1:0]    done_hart_q;
   logic [REG_ADDR_W-1:0]   done_rd_q;

   // Request handshake: a request transfers on a rising edge where
   // muldiv_start=1 and muldiv_busy=0; otherwise the strobe is ignored.

   logic              a_signed, b_signed, a_neg, b_neg, is_div;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res_d;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (muldiv_op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_neg    = a_signed & muldiv_a[XLEN-1];
      b_neg    = b_signed & muldiv_b[XLEN-1];
      a_mag    = a_neg ? (~muldiv_a + 1'b1) : muldiv_a;
      b_mag    = b_neg ? (~muldiv_b + 1'b1) : muldiv_b;
      is_div   = muldiv_op[2];
      div_zero = is_div && (muldiv_b == '0);
      div_ovf  = is_div && a_signed && (muldiv_a == XMIN) && (muldiv_b == '1);
      if (div_zero) spec_res_d = muldiv_op[1] ? muldiv_a : '1;
      else          spec_res_d = muldiv_op[1] ? '0 : XMIN;
   end

   // One iteration step; acc_q low half holds the multiplier (mul) or the
   // dividend/quotient (div), high half the partial product or remainder.
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] acc_d;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      if (op_q[2]) begin
         acc_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc_q[XLEN-2:0], ~div_diff[XLEN]};
      end else if (acc_q[0]) begin
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end else begin
         acc_d = {1'b0, acc_q[2*XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot_fin, rem_fin, mul_res, div_res, result_d;

   always_comb begin
      prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
      quot_fin = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fin  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_res  = op_q[1] ? rem_fin : quot_fin;
      if (special_q)    result_d = spec_res_q;
      else if (op_q[2]) result_d = div_res;
      else              result_d = mul_res;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
         special_q   <= 1'b0;
         spec_res_q  <= '0;
         opnd_q      <= '0;
         acc_q       <= '0;
         hart_q      <= '0;
         rd_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         done_hart_q <= '0;
         done_rd_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (muldiv_start) begin
                  state_q    <= S_CALC;
                  busy_q     <= 1'b1;
                  cnt_q      <= CNT_W'(XLEN);
                  op_q       <= muldiv_op;
                  neg_q      <= a_neg ^ b_neg;
                  rem_neg_q  <= a_neg;
                  special_q  <= div_zero | div_ovf;
                  spec_res_q <= spec_res_d;
                  opnd_q     <= is_div ? b_mag : a_mag;
                  acc_q      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                  hart_q     <= muldiv_hart_id;
                  rd_q       <= muldiv_rd;
               end
            end
            S_CALC: begin
               if (cnt_q != '0) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q     <= S_FIN;
                  done_q      <= 1'b1;
                  result_q    <= result_d;
                  done_hart_q <= hart_q;
                  done_rd_q   <= rd_q;
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign muldiv_busy         = busy_q;
   assign muldiv_done         = done_q;
   assign muldiv_result       = result_q;
   assign muldiv_done_hart_id = done_hart_q;
   assign muldiv_done_rd      = done_rd_q;
   assign muldiv_dbg_state    = state_q;

endmodule
